// File: rtl/tiny16_trace_if.sv
// Purpose: snoop and readout bundle between the tiny16 GPR write port and the trace block.
// Latency: wiring only, no state.
// Backpressure: rd_valid/rd_ready handshake on the readout side; the snoop side cannot be stalled.
interface tiny16_trace_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int TS_W   = 16
);
    localparam int ENT_W = TS_W + REG_AW + DATA_W;

    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ENT_W-1:0]  rd_data;
    logic              rd_valid;
    logic              rd_ready;

    // Core / consumer side
    modport master (
        output we, waddr, wdata, rd_ready,
        input  rd_data, rd_valid
    );

    // Trace block side
    modport slave (
        input  we, waddr, wdata, rd_ready,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/tiny16_trace.sv
// Purpose: captures {timestamp, reg, data} of GPR writes around a trigger into a circular buffer.
// Latency: an entry is stored on the edge its write is sampled; readout presents one entry per cycle.
// Backpressure: rd_data is held while rd_valid & !rd_ready; the snoop is never stalled (oldest entry is overwritten).
module tiny16_trace #(
    parameter int  DATA_W = 16,
    parameter int  REG_AW = 3,
    parameter int  DEPTH  = 16,
    parameter int  TS_W   = 16,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    tiny16_trace_if.slave     bus,
    input  logic              arm,
    input  logic [1:0]        trig_mode,
    input  logic [REG_AW-1:0] trig_reg,
    input  logic [DATA_W-1:0] trig_val,
    input  logic [PTR_W:0]    post_len,
    output logic [1:0]        state,
    output logic [PTR_W:0]    level,
    output logic              trig_hit
);
    localparam int ENT_W = TS_W + REG_AW + DATA_W;
    localparam logic [PTR_W:0]   FULL_LVL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   MAX_POST = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            st_q, st_d;
    logic [TS_W-1:0]   ts_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    level_q;
    logic [PTR_W-1:0]  post_cnt_q;
    logic              trig_hit_q;
    logic [ENT_W-1:0]  rd_data_q;
    logic [ENT_W-1:0]  mem [DEPTH];

    logic              wr_en;
    logic              clr;
    logic              fire;
    logic              pop;
    logic              full;
    logic              match;
    logic              rd_valid;
    logic [PTR_W-1:0]  post_clamp;
    logic [ENT_W-1:0]  wr_entry;

    assign full     = (level_q == FULL_LVL);
    assign wr_entry = {ts_q, bus.waddr, bus.wdata};
    // Clamping to DEPTH-1 keeps the trigger entry from being overwritten by post writes
    assign post_clamp = (post_len > MAX_POST) ? MAX_POST[PTR_W-1:0] : post_len[PTR_W-1:0];
    assign rd_valid   = (st_q == S_DONE) && (level_q != '0);

    // Trigger qualifier, evaluated live against the current mode/register/value
    always_comb begin
        match = 1'b0;
        case (trig_mode)
            2'd0:    match = bus.we;
            2'd1:    match = bus.we && (bus.waddr == trig_reg);
            2'd2:    match = bus.we && (bus.waddr == trig_reg) && (bus.wdata == trig_val);
            default: match = 1'b0;
        endcase
    end

    // Next-state and per-cycle control strobes; arm overrides everything, including a same-cycle write
    always_comb begin
        st_d  = st_q;
        wr_en = 1'b0;
        clr   = 1'b0;
        fire  = 1'b0;
        pop   = 1'b0;
        if (arm) begin
            st_d = S_ARMED;
            clr  = 1'b1;
        end else begin
            case (st_q)
                S_IDLE: st_d = S_IDLE;
                S_ARMED: begin
                    if (bus.we) begin
                        wr_en = 1'b1;
                        if (match) begin
                            fire = 1'b1;
                            st_d = (post_clamp == '0) ? S_DONE : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (bus.we) begin
                        wr_en = 1'b1;
                        if (post_cnt_q == PTR_ONE) st_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (level_q == '0) begin
                        st_d = S_IDLE;
                    end else if (bus.rd_ready) begin
                        pop = 1'b1;
                        if (level_q == (PTR_W+1)'(1)) st_d = S_IDLE;
                    end
                end
                default: st_d = S_IDLE;
            endcase
        end
    end

    // Read pointer moves on a pop or when a write into a full buffer evicts the oldest entry
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            rd_ptr_d = '0;
        end else if ((wr_en && full) || pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_q <= S_IDLE;
        else        st_q <= st_d;
    end

    // Timestamp, pointers, occupancy, post counter, sticky trigger flag and registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            post_cnt_q <= '0;
            trig_hit_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            ts_q     <= ts_q + TS_W'(1);
            rd_ptr_q <= rd_ptr_d;
            // Forward the entry being written so the first entry is readable the cycle DONE is entered
            rd_data_q <= (wr_en && (wr_ptr_q == rd_ptr_d)) ? wr_entry : mem[rd_ptr_d];
            if (clr) begin
                wr_ptr_q   <= '0;
                level_q    <= '0;
                post_cnt_q <= '0;
                trig_hit_q <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                    if (!full) level_q <= level_q + (PTR_W+1)'(1);
                end
                if (pop) level_q <= level_q - (PTR_W+1)'(1);
                if (fire) begin
                    trig_hit_q <= 1'b1;
                    post_cnt_q <= post_clamp;
                end else if (wr_en && (st_q == S_POST)) begin
                    post_cnt_q <= post_cnt_q - PTR_ONE;
                end
            end
        end
    end

    // Entry storage; contents survive reset and are only meaningful below the occupancy level
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_entry;
    end

    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = rd_valid ? rd_data_q : '0;
    assign state        = st_q;
    assign level        = level_q;
    assign trig_hit     = trig_hit_q;
endmodule
